// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: carries decoded control and operands into EXE,
// squashing on flush, holding on freeze and inserting bubbles on load-use hazards.
module id_exe_reg #(
    parameter int WORD_LEN          = 16,
    parameter int REG_FILE_ADDR_LEN = 4,
    parameter int EXE_CMD_LEN       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         flush,
    input  logic                         hazard_detected,
    input  logic                         WB_EN_in,
    input  logic                         MEM_R_EN_in,
    input  logic                         MEM_W_EN_in,
    input  logic [EXE_CMD_LEN-1:0]       EXE_CMD_in,
    input  logic [WORD_LEN-1:0]          val1_in,
    input  logic [WORD_LEN-1:0]          val2_in,
    input  logic [WORD_LEN-1:0]          st_val_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2_forw_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
    input  logic [7:0]                   SLLAmount_in,
    input  logic [1:0]                   branch_comm_in,
    input  logic [WORD_LEN-1:0]          PC_in,
    output logic                         WB_EN_out,
    output logic                         MEM_R_EN_out,
    output logic                         MEM_W_EN_out,
    output logic [EXE_CMD_LEN-1:0]       EXE_CMD_out,
    output logic [WORD_LEN-1:0]          val1_out,
    output logic [WORD_LEN-1:0]          val2_out,
    output logic [WORD_LEN-1:0]          st_val_out,
    output logic [REG_FILE_ADDR_LEN-1:0] src1_out,
    output logic [REG_FILE_ADDR_LEN-1:0] src2_forw_out,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
    output logic [7:0]                   SLLAmount_out,
    output logic [1:0]                   branch_comm_out,
    output logic [WORD_LEN-1:0]          PC_out,
    output logic                         valid_out,
    output logic [7:0]                   bubble_cnt
);

    logic bubble;
    logic load_data;
    logic load_ctrl;

    // flush squashes even while frozen; a hazard only squashes when not frozen
    assign bubble    = flush || (hazard_detected && !freeze);
    assign load_data = !flush && !freeze;
    assign load_ctrl = load_data && !hazard_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_EN_out       <= 1'b0;
            MEM_R_EN_out    <= 1'b0;
            MEM_W_EN_out    <= 1'b0;
            EXE_CMD_out     <= '0;
            branch_comm_out <= '0;
            valid_out       <= 1'b0;
            bubble_cnt      <= '0;
        end else if (bubble) begin
            // constants only, so X control inputs never reach a bubble
            WB_EN_out       <= 1'b0;
            MEM_R_EN_out    <= 1'b0;
            MEM_W_EN_out    <= 1'b0;
            EXE_CMD_out     <= '0;
            branch_comm_out <= '0;
            valid_out       <= 1'b0;
            if (bubble_cnt != 8'hFF)
                bubble_cnt <= bubble_cnt + 8'd1;
        end else if (load_ctrl) begin
            WB_EN_out       <= WB_EN_in;
            MEM_R_EN_out    <= MEM_R_EN_in;
            MEM_W_EN_out    <= MEM_W_EN_in;
            EXE_CMD_out     <= EXE_CMD_in;
            branch_comm_out <= branch_comm_in;
            valid_out       <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val1_out      <= '0;
            val2_out      <= '0;
            st_val_out    <= '0;
            src1_out      <= '0;
            src2_forw_out <= '0;
            dest_out      <= '0;
            SLLAmount_out <= '0;
            PC_out        <= '0;
        end else if (load_data) begin
            val1_out      <= val1_in;
            val2_out      <= val2_in;
            st_val_out    <= st_val_in;
            src1_out      <= src1_in;
            src2_forw_out <= src2_forw_in;
            dest_out      <= dest_in;
            SLLAmount_out <= SLLAmount_in;
            PC_out        <= PC_in;
        end
    end

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed scenarios then random traffic, all compared
// against a field-level reference model of the stage register.
module tb_id_exe_reg;
    localparam int W = 16;
    localparam int A = 4;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    logic freeze, flush, hazard_detected;
    logic WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [C-1:0] EXE_CMD_in;
    logic [W-1:0] val1_in, val2_in, st_val_in, PC_in;
    logic [A-1:0] src1_in, src2_forw_in, dest_in;
    logic [7:0]   SLLAmount_in;
    logic [1:0]   branch_comm_in;

    logic WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, valid_out;
    logic [C-1:0] EXE_CMD_out;
    logic [W-1:0] val1_out, val2_out, st_val_out, PC_out;
    logic [A-1:0] src1_out, src2_forw_out, dest_out;
    logic [7:0]   SLLAmount_out, bubble_cnt;
    logic [1:0]   branch_comm_out;

    always #5 clk = ~clk;

    id_exe_reg #(.WORD_LEN(W), .REG_FILE_ADDR_LEN(A), .EXE_CMD_LEN(C)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .hazard_detected(hazard_detected),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .EXE_CMD_in(EXE_CMD_in), .val1_in(val1_in), .val2_in(val2_in),
        .st_val_in(st_val_in), .src1_in(src1_in), .src2_forw_in(src2_forw_in),
        .dest_in(dest_in), .SLLAmount_in(SLLAmount_in), .branch_comm_in(branch_comm_in),
        .PC_in(PC_in),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out),
        .EXE_CMD_out(EXE_CMD_out), .val1_out(val1_out), .val2_out(val2_out),
        .st_val_out(st_val_out), .src1_out(src1_out), .src2_forw_out(src2_forw_out),
        .dest_out(dest_out), .SLLAmount_out(SLLAmount_out),
        .branch_comm_out(branch_comm_out), .PC_out(PC_out),
        .valid_out(valid_out), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic wb, mr, mw, valid;
        logic [3:0] cmd, s1, s2, d;
        logic [1:0] br;
        logic [7:0] sll;
        logic [15:0] v1, v2, st, pc;
        int cnt;
    } exp_t;

    exp_t e;
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
        compared++;
        assert (obs === ex) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
        end
    endtask

    task automatic check_all();
        chk("wb_en", WB_EN_out, e.wb);
        chk("mem_r", MEM_R_EN_out, e.mr);
        chk("mem_w", MEM_W_EN_out, e.mw);
        chk("exe_cmd", EXE_CMD_out, e.cmd);
        chk("branch", branch_comm_out, e.br);
        chk("valid", valid_out, e.valid);
        chk("bubble_cnt", bubble_cnt, e.cnt);
        chk("val1", val1_out, e.v1);
        chk("val2", val2_out, e.v2);
        chk("st_val", st_val_out, e.st);
        chk("src1", src1_out, e.s1);
        chk("src2", src2_forw_out, e.s2);
        chk("dest", dest_out, e.d);
        chk("sll", SLLAmount_out, e.sll);
        chk("pc", PC_out, e.pc);
    endtask

    task automatic model_reset();
        e = '{default: 0};
    endtask

    // One rising edge of the reference: squash, stall, bubble or plain load.
    task automatic model_edge();
        logic squash;
        squash = flush || (hazard_detected && !freeze);
        if (!flush && !freeze) begin
            e.v1 = val1_in; e.v2 = val2_in; e.st = st_val_in; e.pc = PC_in;
            e.s1 = src1_in; e.s2 = src2_forw_in; e.d = dest_in; e.sll = SLLAmount_in;
        end
        if (squash) begin
            e.wb = 0; e.mr = 0; e.mw = 0; e.cmd = 0; e.br = 0; e.valid = 0;
            e.cnt = (e.cnt + 1 > 255) ? 255 : e.cnt + 1;
        end else if (!freeze) begin
            e.wb = WB_EN_in; e.mr = MEM_R_EN_in; e.mw = MEM_W_EN_in;
            e.cmd = EXE_CMD_in; e.br = branch_comm_in; e.valid = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) model_edge();
        check_all();
    endtask

    task automatic ctl(input logic fl, input logic fr, input logic hz);
        flush = fl; freeze = fr; hazard_detected = hz;
    endtask

    task automatic rand_in();
        WB_EN_in = 1'($urandom); MEM_R_EN_in = 1'($urandom); MEM_W_EN_in = 1'($urandom);
        EXE_CMD_in = 4'($urandom); branch_comm_in = 2'($urandom);
        val1_in = 16'($urandom); val2_in = 16'($urandom); st_val_in = 16'($urandom);
        PC_in = 16'($urandom); src1_in = 4'($urandom); src2_forw_in = 4'($urandom);
        dest_in = 4'($urandom); SLLAmount_in = 8'($urandom);
    endtask

    // Pulse reset between edges and confirm the clear lands before the next edge.
    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        #1 rst = 1'b0;
        #1 check_all();
    endtask

    initial begin
        rst = 1'b1;
        ctl(0, 0, 0);
        rand_in();
        model_reset();
        #12 check_all();
        rst = 1'b0;

        // normal load
        WB_EN_in = 1; MEM_R_EN_in = 0; MEM_W_EN_in = 0; EXE_CMD_in = 4'h1;
        val1_in = 16'h0005; dest_in = 4'h3; branch_comm_in = 0;
        step();
        chk("norm_val1", val1_out, 16'h0005);
        chk("norm_cnt", bubble_cnt, 0);

        // hazard bubble with a store pending in ID
        ctl(0, 0, 1); MEM_W_EN_in = 1; val1_in = 16'h0042;
        step();
        chk("hz_memw", MEM_W_EN_out, 0);
        chk("hz_val1", val1_out, 16'h0042);
        chk("hz_cnt", bubble_cnt, 1);

        // freeze holds everything, hazard ignored
        ctl(0, 0, 0); val2_in = 16'hABCD; MEM_W_EN_in = 0;
        step();
        ctl(0, 1, 1); val2_in = 16'h1111;
        repeat (3) step();
        chk("frz_val2", val2_out, 16'hABCD);
        chk("frz_valid", valid_out, 1);

        // flush beats freeze
        ctl(0, 0, 0); rand_in(); WB_EN_in = 1;
        step();
        ctl(1, 1, 0); rand_in();
        step();
        chk("flfr_valid", valid_out, 0);

        // X control inputs during a bubble stay off the outputs
        ctl(0, 0, 1); WB_EN_in = 1'bx; MEM_W_EN_in = 1'bx; EXE_CMD_in = 'x;
        step();
        ctl(0, 0, 0); rand_in();

        // saturation
        ctl(1, 0, 0);
        repeat (300) begin rand_in(); step(); end
        chk("sat_cnt", bubble_cnt, 255);

        // async reset with cnt=7, valid=1
        ctl(0, 0, 0);
        async_reset_pulse();
        ctl(1, 0, 0);
        repeat (7) step();
        ctl(0, 0, 0); rand_in();
        step();
        chk("pre_rst_cnt", bubble_cnt, 7);
        async_reset_pulse();
        step();
        chk("post_rst_valid", valid_out, 1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            rand_in();
            ctl(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 60) == 0) async_reset_pulse();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter WORD_LEN, 16, data word width.
REQ-002 Parameter REG_FILE_ADDR_LEN, 4, register address width.
REQ-003 Parameter EXE_CMD_LEN, 4, ALU command width.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 freeze  in  1  downstream stall; hold register contents.
REQ-007 flush  in  1  branch taken or jump in ID; squash current ID instruction.
REQ-008 hazard_detected  in  1  load-use hazard; insert bubble.
REQ-009 WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control from ID.
REQ-010 EXE_CMD_in  in  EXE_CMD_LEN  ALU command from ID.
REQ-011 val1_in, val2_in, st_val_in  in  WORD_LEN each  operands and store data (reg2).
REQ-012 src1_in, src2_forw_in, dest_in  in  REG_FILE_ADDR_LEN each  forwarding sources and destination.
REQ-013 SLLAmount_in  in  8  shift amount; branch_comm_in  in  2  branch command.
REQ-014 PC_in  in  WORD_LEN  PC of the instruction in ID.
REQ-015 Registered outputs: same names with _out suffix, same widths, plus valid_out (1) and bubble_cnt (8).

Function
REQ-016 Control fields = WB_EN, MEM_R_EN, MEM_W_EN, EXE_CMD, branch_comm; data fields = all other _in signals.
REQ-017 Priority per edge, highest first: flush, freeze, hazard_detected, normal load.
REQ-018 flush=1: control fields and valid_out SHALL clear to 0; data fields SHALL hold; applies even if freeze=1.
REQ-019 freeze=1, flush=0: every output SHALL hold its value, bubble_cnt included.
REQ-020 hazard_detected=1, flush=0, freeze=0: control fields and valid_out clear to 0; data fields SHALL load (harmless, EXE_CMD=0 is NOP).
REQ-021 Normal load: all fields load from inputs; valid_out SHALL be 1.
REQ-022 Latency: inputs sampled at edge N SHALL appear on outputs after edge N; no combinational input-to-output path.
REQ-023 bubble_cnt SHALL increment by 1 on each edge where flush or (hazard_detected and not freeze) clears the register.
REQ-024 bubble_cnt SHALL saturate at 255; no wrap-around.
REQ-025 A bubble SHALL never assert MEM_W_EN_out or WB_EN_out.
REQ-026 No inputs are registered other than as stated; undriven/X inputs during bubble SHALL not propagate to control outputs.

Reset
REQ-027 rst=1 SHALL asynchronously clear every output to 0, including valid_out and bubble_cnt, independent of clk.
REQ-028 Reset asserted mid-freeze or mid-flush SHALL override both; first edge after rst deassert SHALL follow REQ-017.
REQ-029 Reset deassertion SHALL take effect at the next rising edge; no output change between deassert and that edge.

Verification
REQ-030 Normal: WB_EN_in=1, EXE_CMD_in=4'h1, val1_in=16'h0005, dest_in=4'h3, one edge -> WB_EN_out=1, EXE_CMD_out=1, val1_out=5, dest_out=3, valid_out=1, bubble_cnt=0.
REQ-031 Hazard: load as above, then hazard_detected=1 with MEM_W_EN_in=1 -> all control outputs 0, valid_out=0, val1_out tracks val1_in, bubble_cnt=1.
REQ-032 Freeze: load val2_in=16'hABCD, then freeze=1 for 3 edges with val2_in=16'h1111 and hazard_detected=1 -> val2_out=ABCD, valid_out=1, bubble_cnt unchanged.
REQ-033 Flush+freeze: valid instruction held, assert flush=1 and freeze=1 together -> control outputs 0, valid_out=0, data unchanged, bubble_cnt+1.
REQ-034 Saturation: 300 consecutive flush cycles -> bubble_cnt=255, stays 255.
REQ-035 Async reset: assert rst between clock edges with valid_out=1, bubble_cnt=7 -> all outputs 0 before next edge; release, normal load next edge -> valid_out=1.
